// File: rtl/issue_controller_if.sv
// Fetch/execute/writeback bundle for issue_controller, plus read-only debug taps
// (FSM state, scoreboard, inflight count) for checkers.
interface issue_controller_if;
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
    // The payload must stay stable while valid=1 and ready=0.
    logic        instr_valid;
    logic [48:0] instr;
    logic        instr_ready;
    logic        issue_valid;
    logic [48:0] issue_instr;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        branch_resolved;
    logic        branch_taken;
    logic        flush;
    logic [15:0] stall_cycles;
    logic [1:0]  state_dbg;
    logic [31:0] scoreboard_dbg;
    logic [3:0]  inflight_dbg;

    modport master (
        output instr_valid, instr, ex_ready, wb_valid, wb_dst,
               branch_resolved, branch_taken,
        input  instr_ready, issue_valid, issue_instr, flush, stall_cycles,
               state_dbg, scoreboard_dbg, inflight_dbg
    );

    modport slave (
        input  instr_valid, instr, ex_ready, wb_valid, wb_dst,
               branch_resolved, branch_taken,
        output instr_ready, issue_valid, issue_instr, flush, stall_cycles,
               state_dbg, scoreboard_dbg, inflight_dbg
    );
endinterface

// File: rtl/issue_controller.sv
// Single-slot issue stage with a 32-entry RAW scoreboard and branch resolve/flush FSM.
// Optional macro WB_BYPASS_EN: let a same-cycle writeback clear its hazard before the accept decision.
module issue_controller #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_INF    = 4'(MAX_INFLIGHT);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic        flush_q;
    logic [31:0] scoreboard;
    logic [3:0]  inflight;
    logic        issue_valid_q;
    logic [48:0] issue_instr_q;
    logic [15:0] stall_q;

    logic [4:0]  op;
    logic [1:0]  mode;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic        is_branch;
    logic        is_store;
    logic        writes;
    logic        reads_src;
    logic [31:0] wb_mask;
    logic        wb_dec;
    logic [31:0] sb_view;
    logic [3:0]  inflight_view;
    logic        hazard;
    logic        slot_free;
    logic        ready;
    logic        accept;
    logic        accept_write;
    logic [31:0] sb_next;
    logic [3:0]  inflight_next;

    always_comb begin
        op        = bus.instr[48:44];
        mode      = bus.instr[43:42];
        src       = bus.instr[41:37];
        dst       = bus.instr[36:32];
        is_branch = (op == 5'h10) || (op == 5'h11) || (op == 5'h12);
        is_store  = (op == 5'h02);
        writes    = !is_branch && !is_store;
        reads_src = (mode == 2'b00);
    end

    always_comb begin
        wb_mask = bus.wb_valid ? (32'd1 << bus.wb_dst) : 32'd0;
        wb_dec  = bus.wb_valid && (inflight != 4'd0);
`ifdef WB_BYPASS_EN
        sb_view       = scoreboard & ~wb_mask;
        inflight_view = inflight - {3'b000, wb_dec};
`else
        sb_view       = scoreboard;
        inflight_view = inflight;
`endif
    end

    // dst is always a source operand in this ISA, so a pending write to it blocks issue too.
    always_comb begin
        hazard = sb_view[dst]
              || (reads_src && sb_view[src])
              || (writes && (inflight_view == MAX_INF));
        slot_free    = !issue_valid_q || bus.ex_ready;
        ready        = !rst && (state == RUN) && !hazard && slot_free;
        accept       = bus.instr_valid && ready;
        accept_write = accept && writes;
    end

    // Clear-then-set ordering keeps a freshly accepted write pending when wb hits the same register.
    always_comb begin
        sb_next       = scoreboard & ~wb_mask;
        if (accept_write) begin
            sb_next = sb_next | (32'd1 << dst);
        end
        inflight_next = inflight + {3'b000, accept_write} - {3'b000, wb_dec};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_q   <= 1'b0;
            flush_cnt <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    flush_q <= 1'b0;
                    if (accept && is_branch) begin
                        state <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (bus.branch_resolved) begin
                        if (bus.branch_taken) begin
                            state     <= FLUSH;
                            flush_q   <= 1'b1;
                            flush_cnt <= FLUSH_LAST;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state   <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    // Flush only kills upstream work; the slot and scoreboard belong to older instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scoreboard    <= 32'd0;
            inflight      <= 4'd0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= 49'd0;
            stall_q       <= 16'd0;
        end else begin
            scoreboard <= sb_next;
            inflight   <= inflight_next;
            if (accept) begin
                issue_valid_q <= 1'b1;
                issue_instr_q <= bus.instr;
            end else if (bus.ex_ready) begin
                issue_valid_q <= 1'b0;
            end
            if (bus.instr_valid && !ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign bus.instr_ready    = ready;
    assign bus.issue_valid    = issue_valid_q;
    assign bus.issue_instr    = issue_instr_q;
    assign bus.flush          = flush_q;
    assign bus.stall_cycles   = stall_q;
    assign bus.state_dbg      = state;
    assign bus.scoreboard_dbg = scoreboard;
    assign bus.inflight_dbg   = inflight;

endmodule
